ps2_key_sequencer: RTL

Controller that sits directly behind the PS/2 byte receiver and turns its raw byte stream into decoded keyboard events. Tracks the 0xE0 (extended) and 0xF0 (break) prefix sequence and filters non-key protocol bytes. Buffers completed events in a small show-ahead FIFO for the CPU-side consumer. Also supervises the receiver: on a sticky parity error it pulses the receiver's reset, drops any partial sequence and counts the fault.

---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_event_fifo.sv | 55 +++++
 rtl/ps2_key_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode constants, sequencer states and key-event layout.
// Imported by the event FIFO and the key sequencer.
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_RECOVER
  } seq_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  localparam int EV_W = $bits(key_event_t);

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_E0) || (b == SC_F0);
  endfunction

  function automatic logic is_protocol(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_BAT) ||
           (b == SC_ECHO) || (b == SC_ACK) ||
           (b == SC_RESEND) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead FIFO of decoded key events.
// Head reads as zero when the FIFO is empty.
import ps2_pkg::*;

module ps2_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [EV_W-1:0] push_data,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [EV_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [EV_W-1:0] mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            do_push;
  logic            do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns PS/2 receiver bytes into make/break key events with E0 tracking,
// and supervises the receiver through parity-error recovery.
import ps2_pkg::*;

module ps2_key_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic       slowClk,
  input  logic       resetN,
  input  logic       rxReceived,
  input  logic [7:0] rxValue,
  input  logic       rxError,
  output logic       rxReset,
  output logic       keyValid,
  output logic [7:0] keyCode,
  output logic       keyRelease,
  output logic       keyExtended,
  input  logic       keyPop,
  output logic       overflow,
  output logic [7:0] errorCount
);

  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_e  state_q, state_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  pend_byte_q, pend_byte_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]  rec_q, rec_d;
  logic [7:0]  err_q, err_d;
  logic        ovf_q, ovf_d;

  logic        commit;
  logic        tmo_hit;
  logic        push;
  key_event_t  push_ev;
  logic        fifo_full;
  logic        fifo_empty;
  logic [EV_W-1:0] head;

  assign commit  = pend_vld_q && !rxError;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = 1'b0;
    pend_byte_d = pend_byte_q;
    rec_d       = rec_q;
    err_d       = err_q;
    push        = 1'b0;
    push_ev     = '0;
    if (rxReceived && state_q != ST_RECOVER) begin
      pend_vld_d  = 1'b1;
      pend_byte_d = rxValue;
    end
    if (rxError && state_q != ST_RECOVER) begin
      state_d    = ST_RECOVER;
      pend_vld_d = 1'b0;
      rec_d      = '0;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (commit) begin
            unique case (1'b1)
              pend_byte_q == SC_E0: state_d = ST_GOT_E0;
              pend_byte_q == SC_F0: state_d = ST_GOT_F0;
              is_protocol(pend_byte_q): ;
              default: begin
                push    = 1'b1;
                push_ev = '{ext: 1'b0, rel: 1'b0, code: pend_byte_q};
              end
            endcase
          end
        end
        ST_GOT_E0: begin
          if (commit) begin
            unique case (1'b1)
              pend_byte_q == SC_F0: state_d = ST_GOT_E0F0;
              pend_byte_q == SC_E0: ;
              default: begin
                push    = 1'b1;
                push_ev = '{ext: 1'b1, rel: 1'b0, code: pend_byte_q};
                state_d = ST_IDLE;
              end
            endcase
          end else if (tmo_hit) begin
            state_d = ST_IDLE;
          end
        end
        ST_GOT_F0, ST_GOT_E0F0: begin
          if (commit) begin
            state_d = ST_IDLE;
            if (!is_prefix(pend_byte_q)) begin
              push    = 1'b1;
              push_ev = '{ext: state_q == ST_GOT_E0F0,
                          rel: 1'b1, code: pend_byte_q};
            end
          end else if (tmo_hit) begin
            state_d = ST_IDLE;
          end
        end
        ST_RECOVER: begin
          pend_vld_d = 1'b0;
          if (rec_q != 2'd2) rec_d = rec_q + 2'd1;
          else if (!rxError) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Any committed byte or state change restarts the inter-byte window.
  always_comb begin
    tmo_d = '0;
    if (state_d == state_q && !commit &&
        (state_q == ST_GOT_E0 || state_q == ST_GOT_F0 ||
         state_q == ST_GOT_E0F0))
      tmo_d = tmo_q + TW'(1);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !keyPop) ovf_d = 1'b1;
  end

  always_ff @(posedge slowClk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      pend_vld_q  <= 1'b0;
      pend_byte_q <= '0;
      tmo_q       <= '0;
      rec_q       <= '0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_byte_q <= pend_byte_d;
      tmo_q       <= tmo_d;
      rec_q       <= rec_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (slowClk),
    .rst_n    (resetN),
    .push     (push),
    .push_data(push_ev),
    .pop      (keyPop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign rxReset    = (state_q == ST_RECOVER) && (rec_q != 2'd2);
  assign keyValid   = !fifo_empty;
  assign keyExtended = head[EV_W-1];
  assign keyRelease = head[EV_W-2];
  assign keyCode    = head[7:0];
  assign overflow   = ovf_q;
  assign errorCount = err_q;

endmodule
